// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon burst responder slice.
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    READ_BURST  = 2'd2
  } state_t;

  localparam int BURST_COUNT_WIDTH = 8;

  function automatic int byteLanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/avalon_burst_responder_ram.sv
// Single-port byte-enabled synchronous RAM with 1-cycle read latency.
// The read register holds between reads; the array itself is never reset.
module avalon_burst_responder_ram
  import avalon_pkg::*;
#(
  parameter int Width        = 32,
  parameter int AddressWidth = 10
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic                    ipWrite,
  input  logic                    ipRead,
  input  logic [AddressWidth-1:0] ipAddress,
  input  logic [Width/8-1:0]      ipByteEnable,
  input  logic [Width-1:0]        ipWriteData,
  output logic [Width-1:0]        opReadData
);

  localparam int Lanes = byteLanes(Width);
  localparam int Depth = 1 << AddressWidth;

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_readData;

  always_ff @(posedge ipClk) begin
    if (ipWrite) begin
      for (int b = 0; b < Lanes; b++) begin
        if (ipByteEnable[b]) begin
          r_mem[ipAddress][b*8 +: 8] <= ipWriteData[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_readData <= '0;
    end else if (ipRead) begin
      r_readData <= r_mem[ipAddress];
    end
  end

  assign opReadData = r_readData;

endmodule

// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst responder serving pipelined burst reads/writes from an internal RAM.
// Define AVALON_BURST_RESPONDER_OUTREG_EN to add an output register on ReadData/ReadValid.
module avalon_burst_responder
  import avalon_pkg::*;
#(
  parameter int Width        = 32,
  parameter int AddressWidth = 10
) (
  input  logic                         ipClk,
  input  logic                         ipReset,
  output logic                         opAvalon_WaitRequest,
  input  logic [AddressWidth-1:0]      ipAvalon_Address,
  input  logic [Width/8-1:0]           ipAvalon_ByteEnable,
  input  logic [BURST_COUNT_WIDTH-1:0] ipAvalon_BurstCount,
  input  logic [Width-1:0]             ipAvalon_WriteData,
  input  logic                         ipAvalon_Write,
  input  logic                         ipAvalon_Read,
  output logic [Width-1:0]             opAvalon_ReadData,
  output logic                         opAvalon_ReadValid
);

  // Cycles spent in READ_BURST after the last RAM read before WaitRequest drops.
`ifdef AVALON_BURST_RESPONDER_OUTREG_EN
  localparam logic [1:0] DrainCycles = 2'd2;
`else
  localparam logic [1:0] DrainCycles = 2'd1;
`endif

  state_t                         r_state;
  logic [AddressWidth-1:0]        r_addr;
  logic [BURST_COUNT_WIDTH-1:0]   r_count;
  logic [1:0]                     r_drain;
  logic                           r_waitRequest;
  logic                           r_readValid;

  logic                           w_ramWrite;
  logic                           w_ramRead;
  logic [AddressWidth-1:0]        w_ramAddr;
  logic [BURST_COUNT_WIDTH-1:0]   w_burstLen;
  logic [Width-1:0]               w_ramData;

  assign w_burstLen = (ipAvalon_BurstCount == '0) ? BURST_COUNT_WIDTH'(1) : ipAvalon_BurstCount;
  assign w_ramWrite = !ipReset && !r_waitRequest && ipAvalon_Write && (r_state != READ_BURST);
  assign w_ramRead  = !ipReset && (r_state == READ_BURST) && (r_count != '0);
  assign w_ramAddr  = (r_state == IDLE) ? ipAvalon_Address : r_addr;

  avalon_burst_responder_ram #(
    .Width        (Width),
    .AddressWidth (AddressWidth)
  ) u_ram (
    .ipClk        (ipClk),
    .ipReset      (ipReset),
    .ipWrite      (w_ramWrite),
    .ipRead       (w_ramRead),
    .ipAddress    (w_ramAddr),
    .ipByteEnable (ipAvalon_ByteEnable),
    .ipWriteData  (ipAvalon_WriteData),
    .opReadData   (w_ramData)
  );

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_count       <= '0;
      r_drain       <= '0;
      r_waitRequest <= 1'b1;
      r_readValid   <= 1'b0;
    end else begin
      r_readValid <= w_ramRead;
      case (r_state)
        IDLE: begin
          r_waitRequest <= 1'b0;
          if (!r_waitRequest && ipAvalon_Write) begin
            r_addr  <= ipAvalon_Address + 1'b1;
            r_count <= w_burstLen - 1'b1;
            if (w_burstLen != BURST_COUNT_WIDTH'(1)) begin
              r_state <= WRITE_BURST;
            end
          end else if (!r_waitRequest && ipAvalon_Read) begin
            r_addr        <= ipAvalon_Address;
            r_count       <= w_burstLen;
            r_drain       <= DrainCycles;
            r_waitRequest <= 1'b1;
            r_state       <= READ_BURST;
          end
        end
        WRITE_BURST: begin
          if (ipAvalon_Write) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count - 1'b1;
            if (r_count == BURST_COUNT_WIDTH'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        READ_BURST: begin
          if (r_count != '0) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count - 1'b1;
          end else if (r_drain == 2'd1) begin
            r_waitRequest <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_drain <= r_drain - 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign opAvalon_WaitRequest = r_waitRequest;

`ifdef AVALON_BURST_RESPONDER_OUTREG_EN
  logic             r_readValidQ;
  logic [Width-1:0] r_readDataQ;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_readValidQ <= 1'b0;
      r_readDataQ  <= '0;
    end else begin
      r_readValidQ <= r_readValid;
      if (r_readValid) begin
        r_readDataQ <= w_ramData;
      end
    end
  end

  assign opAvalon_ReadValid = r_readValidQ;
  assign opAvalon_ReadData  = r_readDataQ;
`else
  assign opAvalon_ReadValid = r_readValid;
  assign opAvalon_ReadData  = w_ramData;
`endif

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
- Avalon-MM burst-capable slave (responder) terminating the master-side bus produced by the arbiter layer.
- Serves pipelined burst reads and burst writes against an internal single-port synchronous RAM of 2^AddressWidth words.
- Drives WaitRequest, ReadData and ReadValid back to the master.
- Used as on-chip scratch or frame memory behind the arbiter.

Parameters:
- Width, 32, data bus width in bits (multiple of 8).
- AddressWidth, 10, word-address width; RAM depth = 2^AddressWidth words.

Ports:
- ipClk  in  1  single clock; all logic on rising edge.
- ipReset  in  1  synchronous, active-high reset.
- opAvalon_WaitRequest  out  1  slave stall; registered.
- ipAvalon_Address  in  AddressWidth  word address of first beat.
- ipAvalon_ByteEnable  in  Width/8  per-byte write enables.
- ipAvalon_BurstCount  in  8  beats in burst; 0 treated as 1.
- ipAvalon_WriteData  in  Width  write beat data.
- ipAvalon_Write  in  1  write request/beat valid.
- ipAvalon_Read  in  1  read request.
- opAvalon_ReadData  out  Width  read beat data.
- opAvalon_ReadValid  out  1  ReadData valid this cycle.

Behaviour:
- Reset values:
  - opAvalon_WaitRequest=1; goes 0 the first cycle after ipReset deasserts.
  - opAvalon_ReadValid=0, opAvalon_ReadData=0, state=IDLE, counters=0.
  - RAM contents not reset.
- Acceptance: a command or beat is accepted on an edge where Read or Write is high and opAvalon_WaitRequest is low.
- States: IDLE, WRITE_BURST, READ_BURST.
- IDLE:
  - WaitRequest=0.
  - Write accepted: write beat 0 to Address with ByteEnable; latch Address+1 and BurstCount-1. Remaining count 0 -> stay IDLE, else -> WRITE_BURST.
  - Read accepted: latch Address and BurstCount -> READ_BURST.
  - Write and Read both high: Write wins; Read is dropped.
- WRITE_BURST:
  - WaitRequest=0.
  - Each cycle with Write high writes WriteData/ByteEnable to the internal address, increments the address and decrements the count.
  - Write low means master stall: hold state, no RAM write.
  - Address and BurstCount are ignored after beat 0. Read in this state is ignored.
  - Last beat written -> IDLE.
- READ_BURST (L = burst length):
  - Accept edge is cycle 0.
  - WaitRequest is high from cycle 1 to cycle L+1.
  - RAM reads are issued on cycles 1..L at incrementing addresses.
  - RAM has 1-cycle latency, so ReadValid is high on cycles 2..L+1, one beat per cycle, no gaps.
  - WaitRequest returns low at cycle L+2, when the FSM is back in IDLE. The next command can be accepted from cycle L+2.
- Address arithmetic: increments are modulo 2^AddressWidth; bursts wrap silently from the top address to 0.
- BurstCount: 8-bit unsigned, 1..255 honoured; 0 behaves exactly as 1.
- ReadData: holds its last value when ReadValid=0.
- Reset mid-burst: abort immediately. No further RAM writes or ReadValid; FSM returns to IDLE. Partially written data remains in RAM.

Optional Feature:
- Macro: AVALON_BURST_RESPONDER_OUTREG_EN.
- Defined:
  - Adds an output register stage on ReadData/ReadValid, so ReadValid is on cycles 3..L+2.
  - WaitRequest is high from cycle 1 to cycle L+2 and low at L+3.
  - Eases timing at high Width.
- Undefined: timing exactly as in Behaviour.
- Write path unaffected in both cases.

Decomposition:
- Shared package avalon_pkg:
  - State enum (IDLE, WRITE_BURST, READ_BURST).
  - BURST_COUNT_WIDTH=8.
  - Helper constant for byte-lane count (Width/8).
- One sub-module, avalon_burst_responder_ram: single-port byte-enabled synchronous RAM with 1-cycle read latency, parameterised by Width and AddressWidth. The responder FSM, counters and output pipeline stay in the top module.

Test Plan:
- Single write then read: write 0xDEADBEEF to addr 5 (BurstCount 1, BE=0xF); read addr 5, BC 1 -> ReadValid only at cycle 2 with 0xDEADBEEF; WaitRequest high cycles 1-2, low at 3.
- Burst read timing: preload addrs 16..19 with 1..4; read addr 16, BC 4 -> ReadValid cycles 2-5 with data 1,2,3,4; WaitRequest low at cycle 6. With OUTREG_EN: ReadValid cycles 3-6, WaitRequest low at 7.
- Stalled write burst with byte enables: write BC 3 at addr 100, Write deasserted 2 cycles between beats 1 and 2, beat 2 BE=0x3 over 0xFFFFFFFF with data 0x12345678 -> addrs 100,101 hold full beats; addr 102 = 0xFFFF5678.
- Wrap and BurstCount 0: write BC 2 at addr 1023 (AddressWidth 10) -> beats land at 1023 and 0. Read BC 0 at addr 0 -> exactly one ReadValid.
- Simultaneous Read+Write in IDLE at addr 7 (data 0xA5A5A5A5) -> RAM[7]=0xA5A5A5A5, no ReadValid ever, WaitRequest stays 0.
- Reset mid-read: read BC 8, assert ipReset at cycle 4 -> ReadValid 0 from next edge. WaitRequest 1 during reset, 0 the cycle after release. A new read BC 1 then returns correct data.
